// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the branch target buffer entry layout and counter helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = 32 - 2 - BTB_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        word_t                target;
        logic [1:0]           ctr;
    } btb_entry_t;

    // 2-bit direction counter: saturates at 2'b11 when taken and at 2'b00 when not taken
    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup of the fetch PC, registered training from resolved branches.
// Lookup latency 0 cycles, update visible the cycle after upd_en; no backpressure, one update accepted per cycle.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 32 - 2 - IDX_W
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t imemaddr,
    output logic  psel,
    output word_t pPC,
    input  logic  upd_en,
    input  word_t upd_pc,
    input  word_t upd_target,
    input  logic  upd_taken
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    word_t              r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic             w_unused;

    // Byte-offset bits never select an entry
    assign w_unused = ^{imemaddr[1:0], upd_pc[1:0]};

    assign w_idx  = imemaddr[IDX_W+1:2];
    assign w_tag  = imemaddr[31:IDX_W+2];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign psel   = w_hit && r_ctr[w_idx][1];
    assign pPC    = psel ? r_target[w_idx] : '0;

    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[31:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (upd_en) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= sat2_update(r_ctr[w_uidx], upd_taken);
                if (upd_taken) begin
                    r_target[w_uidx] <= upd_target;
                end
            end else if (upd_taken) begin
                // New or conflicting branch starts weakly taken
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_ctr[w_uidx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: vector table of per-cycle inputs and expected lookup outputs.
module tb_branch_target_buffer;
    import cpu_types_pkg::*;

    logic  clk = 1'b0;
    logic  nrst;
    word_t imemaddr;
    logic  psel;
    word_t ppc;
    logic  upd_en;
    word_t upd_pc;
    word_t upd_target;
    logic  upd_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .CLK        (clk),
        .nRST       (nrst),
        .imemaddr   (imemaddr),
        .psel       (psel),
        .pPC        (ppc),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    typedef struct {
        logic  rst_n;
        logic  en;
        word_t pc;
        word_t tgt;
        logic  tk;
        word_t la;
        logic  exp_psel;
        word_t exp_ppc;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input word_t p, input word_t t,
                                input logic k, input word_t a, input logic ep, input word_t epc,
                                input string n);
        vec_t v;
        v.rst_n = r; v.en = e; v.pc = p; v.tgt = t; v.tk = k;
        v.la = a; v.exp_psel = ep; v.exp_ppc = epc; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic exp_p, input word_t exp_pc);
        checks++;
        if (psel !== exp_p) begin
            errors++;
            $display("FAIL %s psel: got %b expected %b (imemaddr=%h)", name, psel, exp_p, imemaddr);
        end
        checks++;
        if (ppc !== exp_pc) begin
            errors++;
            $display("FAIL %s pPC: got %h expected %h (imemaddr=%h)", name, ppc, exp_pc, imemaddr);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        nrst       = v.rst_n;
        upd_en     = v.en;
        upd_pc     = v.pc;
        upd_target = v.tgt;
        upd_taken  = v.tk;
        imemaddr   = v.la;
        #3;
        check(v.name, v.exp_psel, v.exp_ppc);
    endtask

    initial begin
        nrst = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; imemaddr = '0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        // Reset state: every address in the low window misses
        for (int a = 0; a <= 'hFC; a += 4) begin
            @(posedge clk);
            #1;
            imemaddr = word_t'(a);
            #3;
            check("reset_sweep", 1'b0, 32'h0);
        end

        add(1, 1, 32'h40,  32'h100, 1, 32'h40,  0, 32'h0,   "alloc_same_cycle_old");
        add(1, 0, 32'h0,   32'h0,   0, 32'h40,  1, 32'h100, "alloc_hit");
        add(1, 0, 32'h0,   32'h0,   0, 32'h440, 0, 32'h0,   "tag_mismatch");
        add(1, 1, 32'h40,  32'h0,   0, 32'h40,  1, 32'h100, "nt1_pre");
        add(1, 1, 32'h40,  32'h0,   0, 32'h40,  0, 32'h0,   "ctr01");
        add(1, 1, 32'h40,  32'h0,   0, 32'h40,  0, 32'h0,   "ctr00");
        add(1, 1, 32'h40,  32'h120, 1, 32'h40,  0, 32'h0,   "ctr00_sat");
        add(1, 1, 32'h40,  32'h120, 1, 32'h40,  0, 32'h0,   "ctr01_up");
        add(1, 1, 32'h40,  32'h120, 1, 32'h40,  1, 32'h120, "ctr10_newtgt");
        add(1, 1, 32'h40,  32'h120, 1, 32'h40,  1, 32'h120, "ctr11");
        add(1, 1, 32'h40,  32'h0,   0, 32'h40,  1, 32'h120, "ctr11_sat");
        add(1, 0, 32'h0,   32'h0,   0, 32'h40,  1, 32'h120, "ctr10_after_sat");
        add(1, 1, 32'h80,  32'h180, 0, 32'h80,  0, 32'h0,   "nt_miss_pre");
        add(1, 0, 32'h0,   32'h0,   0, 32'h80,  0, 32'h0,   "nt_miss_no_alloc");
        add(1, 1, 32'h40,  32'h120, 1, 32'h40,  1, 32'h120, "train_to_11");
        add(1, 1, 32'h440, 32'h200, 1, 32'h440, 0, 32'h0,   "conflict_pre");
        add(1, 0, 32'h0,   32'h0,   0, 32'h40,  0, 32'h0,   "conflict_evicted");
        add(1, 0, 32'h0,   32'h0,   0, 32'h443, 1, 32'h200, "conflict_hit_lowbits");
        add(1, 1, 32'h440, 32'h0,   0, 32'h440, 1, 32'h200, "conflict_nt");
        add(1, 0, 32'h0,   32'h0,   0, 32'h440, 0, 32'h0,   "conflict_ctr_was_10");
        add(1, 1, 32'h440, 32'h210, 1, 32'h440, 0, 32'h0,   "retrain");
        add(0, 1, 32'h40,  32'h300, 1, 32'h440, 1, 32'h210, "reset_cycle_old");
        add(1, 0, 32'h0,   32'h0,   0, 32'h40,  0, 32'h0,   "reset_upd_dropped");
        add(1, 0, 32'h0,   32'h0,   0, 32'h440, 0, 32'h0,   "reset_cleared");

        foreach (vecs[i]) apply(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
